// File: rtl/data_mem_access_unit_pkg.sv
// Shared types for the memory-stage access unit: access sizes, FSM states,
// the latched request record and alignment helpers.
package data_mem_access_unit_pkg;

  localparam int DW = 32;
  localparam int AW = 30;

  typedef enum logic [1:0] {
    BS_WORD = 2'b00,
    BS_BYTE = 2'b01,
    BS_RSVD = 2'b10,
    BS_HALF = 2'b11
  } bytesel_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_e;

  // Halfword lane is picked by address bit 1.
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  typedef struct packed {
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    bytesel_e      size;
    logic          store;
  } req_t;

  // The reserved code behaves as a word access.
  function automatic bytesel_e norm_size(input logic [1:0] sel);
    case (sel)
      2'b01:   return BS_BYTE;
      2'b11:   return BS_HALF;
      default: return BS_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input bytesel_e size, input logic [1:0] lo);
    case (size)
      BS_HALF: return lo[0];
      BS_WORD: return (lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_access_unit_lane_unit.sv
// Combinational lane logic: sign-extended sub-word load extraction and
// sub-word store merge into a RAM word (little-endian lanes).
module lane_unit
  import data_mem_access_unit_pkg::*;
(
  input  logic [DW-1:0] word_i,
  input  logic [1:0]    lane_i,
  input  bytesel_e      size_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] load_o,
  output logic [DW-1:0] merge_o
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = word_i[8*lane_i +: 8];
    sel_half = (lane_i[1] == HALF_HI) ? word_i[31:16] : word_i[15:0];
    load_o   = word_i;
    merge_o  = data_i;
    case (size_i)
      BS_BYTE: begin
        load_o                  = {{24{sel_byte[7]}}, sel_byte};
        merge_o                 = word_i;
        merge_o[8*lane_i +: 8]  = data_i[7:0];
      end
      BS_HALF: begin
        load_o  = {{16{sel_half[15]}}, sel_half};
        merge_o = word_i;
        if (lane_i[1] == HALF_HI) merge_o[31:16] = data_i[15:0];
        else                      merge_o[15:0]  = data_i[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_access_unit.sv
// Memory-stage responder: runs LW/LH/LB/SW/SH/SB against a synchronous-read
// word RAM, doing read-modify-write for sub-word stores, and stalls until done.
module data_mem_access_unit
  import data_mem_access_unit_pkg::*;
(
  input  logic          Clock_i,
  input  logic          Reset_i,
  input  logic          MemRead_i,
  input  logic          MemWrite_i,
  input  logic [1:0]    ByteSel_i,
  input  logic [DW-1:0] Address_i,
  input  logic [DW-1:0] WriteData_i,
  input  logic [DW-1:0] RamRdData_i,
  output logic          RamEn_o,
  output logic          RamWe_o,
  output logic [AW-1:0] RamAddr_o,
  output logic [DW-1:0] RamWrData_o,
  output logic [DW-1:0] ReadData_o,
  output logic          Stall_o,
  output logic          Misaligned_o
);

  state_e        state_q, state_d;
  req_t          req_q, req_d;
  logic          en_q, en_d;
  logic          we_q, we_d;
  logic [DW-1:0] wr_q, wr_d;
  logic [DW-1:0] rd_q, rd_d;
  logic          mis_q, mis_d;

  logic          request;
  bytesel_e      size_in;
  logic          mis_in;
  logic [DW-1:0] load_w, merge_w;

  assign request = MemRead_i | MemWrite_i;
  assign size_in = norm_size(ByteSel_i);
  assign mis_in  = is_misaligned(size_in, Address_i[1:0]);

  lane_unit u_lane (
    .word_i  (RamRdData_i),
    .lane_i  (req_q.addr[1:0]),
    .size_i  (req_q.size),
    .data_i  (req_q.wdata),
    .load_o  (load_w),
    .merge_o (merge_w)
  );

  always_ff @(posedge Clock_i) begin
    if (Reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (request) begin
        if (mis_in)                                 state_d = S_DONE;
        else if (MemWrite_i && size_in == BS_WORD)  state_d = S_WRITE;
        else                                        state_d = S_READ;
      end
      S_READ:  state_d = S_WAIT;
      S_WAIT:  state_d = req_q.store ? S_WRITE : S_DONE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (state_q)
      S_IDLE:                  Stall_o = request;
      S_READ, S_WAIT, S_WRITE: Stall_o = 1'b1;
      default:                 Stall_o = 1'b0;
    endcase
  end

  // Next values for the request latch and the registered RAM/result outputs.
  always_comb begin
    req_d = req_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    mis_d = 1'b0;
    if (state_q == S_IDLE && request) begin
      req_d = '{addr: Address_i, wdata: WriteData_i, size: size_in, store: MemWrite_i};
      mis_d = mis_in;
      if (MemWrite_i && size_in == BS_WORD) wr_d = WriteData_i;
    end
    if (state_q == S_WAIT) begin
      if (req_q.store) wr_d = merge_w;
      else             rd_d = load_w;
    end
    en_d = (state_d == S_READ) || (state_d == S_WRITE);
    we_d = (state_d == S_WRITE);
  end

  always_ff @(posedge Clock_i) begin
    if (Reset_i) begin
      req_q <= '0;
      en_q  <= 1'b0;
      we_q  <= 1'b0;
      wr_q  <= '0;
      rd_q  <= '0;
      mis_q <= 1'b0;
    end else begin
      req_q <= req_d;
      en_q  <= en_d;
      we_q  <= we_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mis_q <= mis_d;
    end
  end

  // A reset landing in the WRITE cycle must keep the RAM from committing.
  assign RamWe_o      = we_q & ~Reset_i;
  assign RamEn_o      = en_q;
  assign RamAddr_o    = req_q.addr[DW-1:2];
  assign RamWrData_o  = wr_q;
  assign ReadData_o   = rd_q;
  assign Misaligned_o = mis_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Directed bench for data_mem_access_unit with a behavioural synchronous RAM.
module tb_data_mem_access_unit;

  logic        clk = 1'b0;
  logic        Reset, MemRead, MemWrite;
  logic [1:0]  ByteSel;
  logic [31:0] Address, WriteData, RamRdData;
  logic        RamEn, RamWe, Stall, Misaligned;
  logic [29:0] RamAddr;
  logic [31:0] RamWrData, ReadData;

  logic [31:0] mem [0:63];
  logic        preload;
  int          en_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  data_mem_access_unit dut (
    .Clock_i(clk), .Reset_i(Reset), .MemRead_i(MemRead), .MemWrite_i(MemWrite),
    .ByteSel_i(ByteSel), .Address_i(Address), .WriteData_i(WriteData),
    .RamRdData_i(RamRdData), .RamEn_o(RamEn), .RamWe_o(RamWe), .RamAddr_o(RamAddr),
    .RamWrData_o(RamWrData), .ReadData_o(ReadData), .Stall_o(Stall),
    .Misaligned_o(Misaligned)
  );

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4] <= 32'h8899AABB;
      mem[6] <= 32'h12345678;
    end else if (RamEn) begin
      en_cnt <= en_cnt + 1;
      if (RamWe) mem[RamAddr[5:0]] <= RamWrData;
      else       RamRdData <= mem[RamAddr[5:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request at a negedge and run to its DONE cycle.
  task automatic access(input logic rd, input logic wr, input logic [1:0] sel,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int stalls, output logic [31:0] rdata, output logic mis);
    stalls = 0;
    @(negedge clk);
    MemRead = rd; MemWrite = wr; ByteSel = sel; Address = addr; WriteData = wd;
    #1;
    while (Stall && stalls < 20) begin
      stalls++;
      @(negedge clk); #1;
    end
    rdata = ReadData;
    mis   = Misaligned;
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  int          st, en0;
  logic [31:0] rdv;
  logic        misv;

  initial begin
    Reset = 1'b1; preload = 1'b1;
    MemRead = 0; MemWrite = 0; ByteSel = 0; Address = 0; WriteData = 0;
    repeat (2) @(negedge clk);
    preload = 1'b0; #1;
    chk("rst_en", {31'b0, RamEn}, 0);
    chk("rst_we", {31'b0, RamWe}, 0);
    chk("rst_addr", {2'b0, RamAddr}, 0);
    chk("rst_wrdata", RamWrData, 0);
    chk("rst_rdata", ReadData, 0);
    chk("rst_mis", {31'b0, Misaligned}, 0);
    chk("rst_stall", {31'b0, Stall}, 0);
    @(negedge clk); Reset = 1'b0;

    access(1, 0, 2'b01, 32'h11, 0, st, rdv, misv);
    chk("lb11_stall", st, 3); chk("lb11_data", rdv, 32'hFFFFFFAA); chk("lb11_mis", {31'b0, misv}, 0);
    access(1, 0, 2'b11, 32'h12, 0, st, rdv, misv);
    chk("lh12_stall", st, 3); chk("lh12_data", rdv, 32'hFFFF8899);
    access(1, 0, 2'b00, 32'h10, 0, st, rdv, misv);
    chk("lw10_data", rdv, 32'h8899AABB);
    access(1, 0, 2'b01, 32'h10, 0, st, rdv, misv); chk("lb10_data", rdv, 32'hFFFFFFBB);
    access(1, 0, 2'b01, 32'h12, 0, st, rdv, misv); chk("lb12_data", rdv, 32'hFFFFFF99);
    access(1, 0, 2'b11, 32'h10, 0, st, rdv, misv); chk("lh10_data", rdv, 32'hFFFFAABB);
    access(1, 0, 2'b01, 32'h1B, 0, st, rdv, misv); chk("lb1b_data", rdv, 32'h00000012);
    access(1, 0, 2'b11, 32'h18, 0, st, rdv, misv); chk("lh18_data", rdv, 32'h00005678);

    access(0, 1, 2'b01, 32'h13, 32'h12345677, st, rdv, misv);
    chk("sb13_stall", st, 4); chk("sb13_ram", mem[4], 32'h7799AABB); chk("sb13_rdata", rdv, 32'h00005678);

    en0 = en_cnt;
    access(0, 1, 2'b00, 32'h14, 32'hDEADBEEF, st, rdv, misv);
    @(negedge clk);
    chk("sw14_stall", st, 2); chk("sw14_ram", mem[5], 32'hDEADBEEF); chk("sw14_en", en_cnt - en0, 1);

    en0 = en_cnt;
    access(0, 1, 2'b11, 32'h11, 32'h0000FFFF, st, rdv, misv);
    chk("sh11_stall", st, 1); chk("sh11_mis", {31'b0, misv}, 1);
    @(negedge clk); #1;
    chk("sh11_pulse", {31'b0, Misaligned}, 0);
    chk("sh11_en", en_cnt - en0, 0); chk("sh11_ram", mem[4], 32'h7799AABB);
    chk("sh11_rdata", ReadData, 32'h00005678);

    access(1, 0, 2'b00, 32'h11, 0, st, rdv, misv);
    chk("lw11_mis", {31'b0, misv}, 1); chk("lw11_rdata", rdv, 32'h00005678);

    access(0, 1, 2'b11, 32'h16, 32'h0000CAFE, st, rdv, misv);
    @(negedge clk);
    chk("sh16_stall", st, 4); chk("sh16_ram", mem[5], 32'hCAFEBEEF);
    access(1, 0, 2'b10, 32'h14, 0, st, rdv, misv);
    chk("lrsv14_data", rdv, 32'hCAFEBEEF);
    access(1, 1, 2'b01, 32'h18, 32'h000000AB, st, rdv, misv);
    @(negedge clk);
    chk("both_stall", st, 4); chk("both_ram", mem[6], 32'h123456AB); chk("both_rdata", rdv, 32'hCAFEBEEF);

    // SH 0x12 with reset hitting the WRITE cycle.
    @(negedge clk);
    MemWrite = 1; ByteSel = 2'b11; Address = 32'h12; WriteData = 32'h00005555;
    repeat (3) @(negedge clk);
    #1; chk("rw_we_pre", {31'b0, RamWe}, 1);
    Reset = 1'b1; MemWrite = 1'b0; #1;
    chk("rw_we_gated", {31'b0, RamWe}, 0);
    @(negedge clk); Reset = 1'b0; #1;
    chk("rw_ram", mem[4], 32'h7799AABB);
    chk("rw_en", {31'b0, RamEn}, 0); chk("rw_addr", {2'b0, RamAddr}, 0);
    chk("rw_rdata", ReadData, 0); chk("rw_stall", {31'b0, Stall}, 0);
    access(1, 0, 2'b00, 32'h10, 0, st, rdv, misv);
    chk("post_rst_stall", st, 3); chk("post_rst_lw", rdv, 32'h7799AABB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
